// File: rtl/led_word_display_pkg.sv
// Shared constants for the LED word display: digit count, blanking codes,
// the decimal-point digit and the hex-to-7-segment lookup table.
// Segment codes are {g,f,e,d,c,b,a} and active low.
package led_word_display_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int DP_DIGIT   = 4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] AN_OFF    = 8'hFF;

    // Packed table: the first element listed is index 15 (F), the last is index 0.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/led_word_display_hex7seg_decoder.sv
// Combinational hex digit to active-low 7-segment decoder.
// Ports:
//   nibble  in  4  hex digit value
//   seg_n   out 7  segments {g,f,e,d,c,b,a}, active low
module hex7seg_decoder
    import led_word_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    assign seg_n = HEX_SEG[nibble];

endmodule

// File: rtl/led_word_display.sv
// Latches the processor's 32-bit led_output word under a minimum-hold rule
// and scans it as 8 hex digits onto a multiplexed active-low 7-seg display.
// Ports:
//   clk           in  1   system clock
//   reset         in  1   synchronous, active high
//   led_output    in  32  word from the processor, sampled every cycle
//   an_n          out 8   digit anodes, active low, bit i = digit i
//   seg_n         out 7   segments {g,f,e,d,c,b,a}, active low
//   dp_n          out 1   decimal point, active low (lit on digit 4)
//   value_shown   out 32  currently latched word
//   update_pulse  out 1   one-cycle strobe when value_shown changes
module led_word_display
    import led_word_display_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16,
    parameter int HOLD_CYCLES  = 25000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] led_output,
    output logic [7:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [31:0] value_shown,
    output logic        update_pulse
);

    localparam int CNT_W  = $clog2(REFRESH_DIV);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int IDX_W  = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);
    localparam logic [IDX_W-1:0]  IDX_DP    = IDX_W'(DP_DIGIT);

    logic [31:0]       value_shown_reg, value_shown_next;
    logic              update_pulse_reg, update_pulse_next;
    logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
    logic [CNT_W-1:0]  refresh_cnt_reg, refresh_cnt_next;
    logic [IDX_W-1:0]  digit_idx_reg, digit_idx_next;
    logic [7:0]        an_n_reg, an_n_next;
    logic [6:0]        seg_n_reg, seg_n_next;
    logic              dp_n_reg, dp_n_next;

    logic [3:0]            nibble_arr [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] an_digit_n;
    logic [3:0]            cur_nibble;
    logic [6:0]            cur_seg_n;
    logic                  hold_expired;
    logic                  load;

    // Split the latched word into digit nibbles and build the one-cold
    // anode pattern for the current digit index.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign nibble_arr[gi] = value_shown_reg[4*gi +: 4];
            assign an_digit_n[gi] = (digit_idx_reg != IDX_W'(gi));
        end
    endgenerate

    assign cur_nibble = nibble_arr[digit_idx_reg];

    hex7seg_decoder u_decoder (
        .nibble (cur_nibble),
        .seg_n  (cur_seg_n)
    );

    assign hold_expired = (hold_cnt_reg == HOLD_MAX);
    // Changes arriving while the hold runs are dropped; whatever is present
    // at the first edge after expiry is what gets loaded.
    assign load = hold_expired && (led_output != value_shown_reg);

    always_comb begin
        value_shown_next  = value_shown_reg;
        update_pulse_next = 1'b0;
        hold_cnt_next     = hold_cnt_reg;
        refresh_cnt_next  = refresh_cnt_reg + CNT_W'(1);
        digit_idx_next    = digit_idx_reg;
        an_n_next         = AN_OFF;
        seg_n_next        = SEG_BLANK;
        dp_n_next         = 1'b1;

        if (load) begin
            value_shown_next  = led_output;
            update_pulse_next = 1'b1;
            hold_cnt_next     = '0;
        end else if (!hold_expired) begin
            hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
        end

        if (refresh_cnt_reg == CNT_LAST) begin
            refresh_cnt_next = '0;
            digit_idx_next   = digit_idx_reg + IDX_W'(1);
        end

        // Anodes stay off for the first cycles of each slot so the previous
        // digit's segments never flash on the new anode.
        if (refresh_cnt_reg >= CNT_BLANK) begin
            an_n_next  = an_digit_n;
            seg_n_next = cur_seg_n;
            dp_n_next  = (digit_idx_reg != IDX_DP);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_shown_reg  <= '0;
            update_pulse_reg <= 1'b0;
            hold_cnt_reg     <= HOLD_MAX;
            refresh_cnt_reg  <= '0;
            digit_idx_reg    <= '0;
            an_n_reg         <= AN_OFF;
            seg_n_reg        <= SEG_BLANK;
            dp_n_reg         <= 1'b1;
        end else begin
            value_shown_reg  <= value_shown_next;
            update_pulse_reg <= update_pulse_next;
            hold_cnt_reg     <= hold_cnt_next;
            refresh_cnt_reg  <= refresh_cnt_next;
            digit_idx_reg    <= digit_idx_next;
            an_n_reg         <= an_n_next;
            seg_n_reg        <= seg_n_next;
            dp_n_reg         <= dp_n_next;
        end
    end

    assign an_n         = an_n_reg;
    assign seg_n        = seg_n_reg;
    assign dp_n         = dp_n_reg;
    assign value_shown  = value_shown_reg;
    assign update_pulse = update_pulse_reg;

endmodule

// File: tb/tb_led_word_display.sv
// Scoreboard bench for led_word_display with small timing parameters.
// The driver issues one input set per clock and pushes the expected
// post-edge outputs; a monitor pops and compares on the falling edge.
module tb_led_word_display;

    localparam int RD   = 6;
    localparam int BLK  = 2;
    localparam int HOLD = 8;

    typedef struct {
        logic [7:0]  an;
        logic [6:0]  seg;
        logic        dp;
        logic        pulse;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] led_output;
    logic [7:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [31:0] value_shown;
    logic        update_pulse;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_loads  = 0;

    // Reference model state: edges since the last reset edge, edges since
    // the last load, and the word currently expected on value_shown.
    int          m_edges;
    int          m_since_load;
    logic [31:0] m_shown;

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    always #5 clk = ~clk;

    led_word_display #(
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BLK),
        .HOLD_CYCLES  (HOLD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .led_output   (led_output),
        .an_n         (an_n),
        .seg_n        (seg_n),
        .dp_n         (dp_n),
        .value_shown  (value_shown),
        .update_pulse (update_pulse)
    );

    // Expected outputs after the coming edge, given the inputs for that edge.
    task automatic model_edge(input logic rst, input logic [31:0] in_val);
        exp_t e;
        int   pos, idx;
        logic [31:0] nib;
        e.an = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1; e.pulse = 1'b0;
        if (rst) begin
            m_shown      = 32'h0;
            m_since_load = HOLD + 1;
            m_edges      = 0;
        end else begin
            m_edges++;
            pos = m_edges - 1;
            idx = (pos / RD) % 8;
            if ((pos % RD) >= BLK) begin
                nib   = (m_shown >> (4 * idx)) & 32'hF;
                e.an  = ~(8'd1 << idx);
                e.seg = hex_tab[nib[3:0]];
                e.dp  = (idx == 4) ? 1'b0 : 1'b1;
            end
            m_since_load++;
            if (m_since_load > HOLD && in_val != m_shown) begin
                m_shown      = in_val;
                m_since_load = 0;
                e.pulse      = 1'b1;
            end
        end
        e.val = m_shown;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic rst, input logic [31:0] v);
        @(posedge clk);
        #1;
        reset      = rst;
        led_output = v;
        model_edge(rst, v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    endtask

    // Monitor: one expectation per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            @(negedge clk);
            if (exp_q.size() == 0) begin
                check("scoreboard_underflow", 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("an_n", {24'h0, an_n}, {24'h0, e.an});
                check("seg_n", {25'h0, seg_n}, {25'h0, e.seg});
                check("dp_n", {31'h0, dp_n}, {31'h0, e.dp});
                check("update_pulse", {31'h0, update_pulse}, {31'h0, e.pulse});
                check("value_shown", value_shown, e.val);
                if (update_pulse) begin
                    n_loads++;
                    $display("load %0d: value_shown=%h", n_loads, value_shown);
                end
            end
        end
    end

    initial begin
        logic [31:0] cur;
        int r;
        m_edges = 0; m_since_load = HOLD + 1; m_shown = 32'h0;

        // Reset for 5 cycles, then idle with zero input.
        reset = 1'b1; led_output = 32'h0;
        model_edge(1'b1, 32'h0);
        for (int i = 0; i < 4; i++) step(1'b1, 32'h0);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0);

        // Immediate load, then changes during the hold.
        step(1'b0, 32'h1234ABCD);
        step(1'b0, 32'h1234ABCD);
        step(1'b0, 32'h1234ABCD);
        for (int i = 0; i < 2; i++) step(1'b0, 32'h0000000F);
        for (int i = 0; i < 12; i++) step(1'b0, 32'h00000010);

        // Full scan of 1234ABCD from a clean reset.
        step(1'b1, 32'h0);
        for (int i = 0; i < 60; i++) step(1'b0, 32'h1234ABCD);

        // Reset during digit 5 with the hold active, then reload at once.
        step(1'b1, 32'h0);
        step(1'b0, 32'hA5A50001);
        for (int k = 2; k <= 27; k++) step(1'b0, 32'hA5A50001);
        step(1'b0, 32'h5A5A0002);
        for (int k = 29; k <= 32; k++) step(1'b0, 32'h5A5A0002);
        step(1'b1, 32'h5A5A0002);
        // Equal input across several hold expiries.
        for (int i = 0; i < 60; i++) step(1'b0, 32'hC0FFEE00);

        // Randomised traffic with occasional resets.
        cur = 32'h0;
        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(0, 9);
            if (r >= 8) cur = $urandom();
            else if (r == 7) cur = (($urandom_range(0, 1)) != 0) ? 32'h1234ABCD : 32'h0;
            step(($urandom_range(0, 149) == 0), cur);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
